// File: rtl/data_memory_be.sv
// data_memory_be: byte-enabled MIPS data memory with extending loads, fault flags and post-reset clear
module data_memory_be #(
   parameter int ADDR_W         = 16,
   parameter int DEPTH_LOG2     = 8,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       writeData,
   input  logic              memWrite,
   input  logic              memRead,
   input  logic [1:0]        size,
   input  logic              unsignedLoad,
   output logic [31:0]       readData,
   output logic              busy,
   output logic              misaligned,
   output logic              outOfRange,
   output logic              errSticky
);
   localparam int WORDS = 1 << DEPTH_LOG2;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nxt;
   logic [DEPTH_LOG2-1:0] ptr;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0] mem [WORDS];
   logic [31:0] word;
   logic [31:0] wdata;
   logic [31:0] load;
   logic [15:0] lane_h;
   logic [7:0] lane_b;
   logic [3:0] be;
   logic access;
   logic fault;
   logic we;

   always_ff @(posedge clock or posedge rst)
      if (rst) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      else state <= state_nxt;

   always_comb state_nxt = (state == CLEAR && &ptr) ? IDLE : state;

   always_comb busy = state == CLEAR;

   always_ff @(posedge clock or posedge rst)
      if (rst) ptr <= '0;
      else if (state == CLEAR) ptr <= ptr + 1'b1;

   always_ff @(posedge clock or posedge rst)
      if (rst) errSticky <= 1'b0;
      else if (!busy && fault) errSticky <= 1'b1;

   always_comb begin
      access     = memRead | memWrite;
      idx        = addr[DEPTH_LOG2+1:2];
      outOfRange = access && ((addr >> (DEPTH_LOG2 + 2)) != '0);
      misaligned = access && (size == 2'b11 || (size == 2'b01 && addr[0]) ||
                              (size == 2'b10 && addr[1:0] != 2'b00));
      fault      = misaligned | outOfRange;
      we         = memWrite && !busy && !fault;
      word       = mem[idx];
      lane_b     = word[{addr[1:0], 3'b000} +: 8];
      lane_h     = addr[1] ? word[31:16] : word[15:0];
      load       = size == 2'b00 ? {{24{lane_b[7] & ~unsignedLoad}}, lane_b} :
                   size == 2'b01 ? {{16{lane_h[15] & ~unsignedLoad}}, lane_h} : word;
      readData   = (memRead && !busy && !fault) ? load : '0;
      be         = size == 2'b00 ? 4'b0001 << addr[1:0] :
                   size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata      = size == 2'b00 ? {4{writeData[7:0]}} :
                   size == 2'b01 ? {2{writeData[15:0]}} : writeData;
   end

   // store data is replicated across lanes so each byte enable picks its own copy
   always_ff @(posedge clock)
      if (busy) mem[ptr] <= '0;
      else if (we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed scoreboard bench for data_memory_be (default parameters)
module tb_data_memory_be;
  localparam int RD = 0, BSY = 1, MIS = 2, OOR = 3, ERR = 4;
  logic clock = 1'b0;
  logic rst;
  logic [15:0] addr;
  logic [31:0] writeData;
  logic memWrite, memRead, unsignedLoad;
  logic [1:0] size;
  logic [31:0] readData;
  logic busy, misaligned, outOfRange, errSticky;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {string name; int sig; logic [31:0] val;} exp_t;
  exp_t sb[$];
  exp_t cur;
  data_memory_be dut (
    .clock(clock), .rst(rst), .addr(addr), .writeData(writeData),
    .memWrite(memWrite), .memRead(memRead), .size(size), .unsignedLoad(unsignedLoad),
    .readData(readData), .busy(busy), .misaligned(misaligned),
    .outOfRange(outOfRange), .errSticky(errSticky)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] observe(input int s);
    return s == RD ? readData : s == BSY ? 32'(busy) : s == MIS ? 32'(misaligned) :
           s == OOR ? 32'(outOfRange) : 32'(errSticky);
  endfunction
  always @(negedge clock)
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_checks++;
      if (observe(cur.sig) !== cur.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", cur.name, observe(cur.sig), cur.val);
      end
    end
  task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r,
                       input logic [1:0] sz, input logic u);
    addr = a; writeData = d; memWrite = w; memRead = r; size = sz; unsignedLoad = u;
  endtask
  task automatic exp(input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    drive(16'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask
  task automatic clear_run(input int n, input int wr_at);
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        drive(16'h0, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0);
        exp(RD, 32'h0, "busy_read");
      end else idle;
      exp(BSY, 32'h1, "clear_busy");
      step;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    idle;
    @(posedge clock);
    #1;
    exp(BSY, 32'h1, "rst_busy"); exp(ERR, 32'h0, "rst_err");
    exp(RD, 32'h0, "rst_rd"); exp(MIS, 32'h0, "rst_mis"); exp(OOR, 32'h0, "rst_oor");
    step;
    rst = 1'b0;
    clear_run(256, -1);
    exp(BSY, 32'h0, "clear_done");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done_direct: got %b expected 0", busy);
    end
    step;
    drive(16'h14, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0); step;
    drive(16'h14, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'hDEADBEEF, "preload"); step;
    rst = 1'b1; idle; exp(BSY, 32'h1, "pulse_busy"); step;
    rst = 1'b0;
    clear_run(256, 200);
    exp(BSY, 32'h0, "pulse_done");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_done_direct: got %b expected 0", busy);
    end
    step;
    drive(16'h14, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h0, "cleared_w5"); step;
    drive(16'h00, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h0, "busy_guard"); step;
    drive(16'h10, 32'h11223344, 1'b1, 1'b0, 2'b10, 1'b0); step;
    drive(16'h12, 32'h000000AA, 1'b1, 1'b0, 2'b00, 1'b0); step;
    drive(16'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h11AA3344, "lw_sb");
    #1;
    n_checks++;
    if (readData !== 32'h11AA3344) begin
      n_fail++;
      $display("FAIL lw_sb_direct: got %h expected 11aa3344", readData);
    end
    step;
    drive(16'h12, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0); exp(RD, 32'hFFFFFFAA, "lb"); step;
    drive(16'h12, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1); exp(RD, 32'h000000AA, "lbu"); step;
    drive(16'h13, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0); exp(RD, 32'h00000011, "lb_top"); step;
    drive(16'h20, 32'hCAFE1234, 1'b1, 1'b0, 2'b10, 1'b0); step;
    drive(16'h22, 32'h00008001, 1'b1, 1'b0, 2'b01, 1'b0); step;
    drive(16'h22, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0); exp(RD, 32'hFFFF8001, "lh"); step;
    drive(16'h22, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1); exp(RD, 32'h00008001, "lhu"); step;
    drive(16'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h80011234, "lw_sh"); step;
    drive(16'h20, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0); exp(RD, 32'h00001234, "lh_low"); step;
    drive(16'h21, 32'h55555555, 1'b1, 1'b0, 2'b10, 1'b0);
    exp(MIS, 32'h1, "sw_mis"); exp(OOR, 32'h0, "sw_mis_oor"); exp(ERR, 32'h0, "err_pre"); step;
    drive(16'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    exp(RD, 32'h80011234, "mis_unchanged"); exp(ERR, 32'h1, "err_set"); exp(MIS, 32'h0, "aligned"); step;
    drive(16'h400, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    exp(OOR, 32'h1, "lw_oor"); exp(RD, 32'h0, "oor_rd"); exp(MIS, 32'h0, "oor_mis");
    #1;
    n_checks++;
    if (outOfRange !== 1'b1 || readData !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_oor_direct: got %b/%h expected 1/00000000", outOfRange, readData);
    end
    step;
    drive(16'h400, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 1'b0); exp(OOR, 32'h1, "sw_oor"); step;
    drive(16'h00, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h0, "oor_no_alias"); step;
    drive(16'h20, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0); exp(MIS, 32'h1, "size11"); exp(RD, 32'h0, "size11_rd"); step;
    drive(16'h21, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0); exp(MIS, 32'h1, "lh_odd"); step;
    idle; exp(ERR, 32'h1, "err_sticky"); exp(MIS, 32'h0, "no_strobe_mis");
    #1;
    n_checks++;
    if (errSticky !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky_direct: got %b expected 1", errSticky);
    end
    step;
    drive(16'h30, 32'h00000001, 1'b1, 1'b0, 2'b10, 1'b0); step;
    drive(16'h30, 32'h00000002, 1'b1, 1'b1, 2'b10, 1'b0); exp(RD, 32'h00000001, "rdw_old"); step;
    drive(16'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h00000002, "rdw_new"); step;
    rst = 1'b1; idle; exp(BSY, 32'h1, "mid_busy0"); step;
    rst = 1'b0;
    clear_run(100, -1);
    rst = 1'b1; exp(BSY, 32'h1, "mid_rst"); step;
    rst = 1'b0;
    clear_run(256, -1);
    exp(BSY, 32'h0, "mid_done"); exp(ERR, 32'h0, "err_cleared");
    n_checks++;
    if (busy !== 1'b0 || errSticky !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_done_direct: got %b/%b expected 0/0", busy, errSticky);
    end
    step;
    drive(16'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); exp(RD, 32'h0, "mid_cleared"); step;
    idle;
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised data memory for the single-cycle MIPS datapath, next generation of the word-only data memory. Adds byte/halfword stores and loads with sign or zero extension, configurable depth and address width, alignment and range checking with a sticky error flag, and a post-reset clear sequencer that zeroes the array one word per cycle. Sits between the ALU result (address), the register file (store data) and the write-back mux (load data).

## Interface
- ADDR_W, 16, byte-address width; DEPTH_LOG2+2 <= ADDR_W required
- DEPTH_LOG2, 8, log2 of word count (WORDS = 2^DEPTH_LOG2)
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset, 0 = contents untouched by reset
- clock  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  byte address
- writeData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- memWrite  in  1  store strobe
- memRead  in  1  load strobe
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- unsignedLoad  in  1  1 = zero-extend byte/half loads, 0 = sign-extend
- readData  out  32  load result, combinational
- busy  out  1  clear sequence in progress
- misaligned  out  1  combinational: current access (memRead|memWrite) is misaligned or size=11
- outOfRange  out  1  combinational: current access addresses beyond WORDS
- errSticky  out  1  registered, set by any faulted access, cleared only by rst

## Operation
- Storage: WORDS x 32 bits, word index = addr[DEPTH_LOG2+1:2], byte offset = addr[1:0], little-endian lanes (offset 0 = bits [7:0]).
- Range: outOfRange=1 when (memRead|memWrite) and addr[ADDR_W-1:DEPTH_LOG2+2] != 0.
- Alignment: half faults when addr[0]=1; word faults when addr[1:0]!=0; size=11 always faults.
- Fault (misaligned|outOfRange): write suppressed, readData=0, errSticky set at next edge.
- Store byte: writeData[7:0] into lane addr[1:0]; store half: writeData[15:0] into lanes {addr[1],0}/{addr[1],1}; store word: full word. Untouched lanes keep their value.
- Load: readData = selected byte/half/word, extended per unsignedLoad; memRead=0 -> readData=0.
- FSM states: IDLE, CLEAR.
  - rst asserted (any time): state<=CLEAR if CLEAR_ON_RESET else IDLE; ptr<=0; errSticky<=0.
  - CLEAR, rst low: each edge writes 0 to word ptr, ptr<=ptr+1; on edge that clears word WORDS-1, state<=IDLE.
  - IDLE: normal accesses.
- busy=1 exactly while state=CLEAR. During busy: memWrite ignored, readData=0, misaligned/outOfRange still reported but errSticky not updated.

## Timing
- Reset values: busy = CLEAR_ON_RESET, errSticky=0, ptr=0; readData/misaligned/outOfRange combinational (0 with strobes low).
- Clear duration: WORDS rising edges after rst deasserts (256 for defaults); busy falls after edge WORDS; first accepted store on edge WORDS+1.
- rst reasserted mid-clear: sequence restarts from ptr=0.
- Load latency: 0 cycles (combinational from addr/size/unsignedLoad/array).
- Store: array updated on the rising edge with memWrite=1.
- memRead and memWrite together, same address: readData shows pre-edge contents; new data visible after the edge.
- ptr width DEPTH_LOG2; no wrap beyond WORDS-1 (FSM exits first).

## Test plan
- Reset clear: preload word 5 = 0xDEADBEEF (CLEAR_ON_RESET=1), pulse rst -> busy=1 for 256 edges, then word 5 reads 0x00000000, busy=0.
- Byte lanes: sw 0x11223344 @0x10; sb 0xAA @0x12 -> lw @0x10 = 0x11AA3344; lb @0x12 = 0xFFFFFFAA; lbu @0x12 = 0x000000AA.
- Halfwords: sh 0x8001 @0x22 -> lh @0x22 = 0xFFFF8001, lhu = 0x00008001, lw @0x20 = 0x8001xxxx with low half unchanged.
- Faults: sw @0x21 -> misaligned=1, word 0x20 unchanged, errSticky=1 next edge; lw @0x0400 (defaults) -> outOfRange=1, readData=0; only rst clears errSticky.
- Busy guard: issue sw 0x12345678 @0x0 during clear -> ignored; after busy falls, lw @0x0 = 0.
- Mid-clear reset and read-during-write: rst at clear cycle 100 -> busy lasts 256 more edges; memRead+memWrite @0x30 old 0x1, new 0x2 -> readData 0x1 before edge, 0x2 after.
